// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: control + data bundles,
// valid/ready handshake, flush, bubble insertion, optional skid entry.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128,
  parameter bit SKID_EN = 1'b1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state;
  state_t state_n;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign main_valid = state[1];
  assign skid_valid = state[0];

  // Skid mode: in_ready comes straight from the skid flop.
  assign in_ready = SKID_EN ? !skid_valid
                            : (!main_valid || out_ready);

  assign in_fire = in_valid && in_ready;

  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            ld_main_in = 1'b1;
            state_n    = ONE;
          end
        end
        ONE: begin
          if (out_ready) begin
            if (in_fire) ld_main_in = 1'b1;
            else         state_n    = EMPTY;
          end else if (in_fire && SKID_EN) begin
            ld_skid = 1'b1;
            state_n = FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            ld_main_skid = 1'b1;
            state_n      = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (ld_main_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (ld_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (ld_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid (a_) and single-entry (b_)
// instances, hand-computed expectations.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 32;
  localparam logic [CW-1:0] BUB = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          a_flush = 0, a_in_valid = 0, a_out_ready = 1;
  logic [CW-1:0] a_in_ctrl = '0;
  logic [DW-1:0] a_in_data = '0;
  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;

  logic          b_flush = 0, b_in_valid = 0, b_out_ready = 1;
  logic [CW-1:0] b_in_ctrl = '0;
  logic [DW-1:0] b_in_data = '0;
  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .BUBBLE_CTRL(BUB)
  ) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .BUBBLE_CTRL(BUB)
  ) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [DW-1:0] d,
                        input logic [CW-1:0] c,
                        input logic rdy);
    a_in_valid  = 1'b1;
    a_in_data   = d;
    a_in_ctrl   = c;
    a_out_ready = rdy;
    tick();
  endtask

  task automatic a_empty(input string tag);
    chk({tag, "_vld"},  32'(a_out_valid), 32'd0);
    chk({tag, "_ctrl"}, 32'(a_out_ctrl),  32'(BUB));
    chk({tag, "_occ"},  32'(a_occ),       32'd0);
  endtask

  initial begin
    // reset state
    #1;
    a_empty("rst");
    chk("rst_data", a_out_data, 32'd0);
    chk("rst_rdy", 32'(a_in_ready), 32'd1);
    chk("rst_b_occ", 32'(b_occ), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      a_push(DW'(i), CW'(8'h10 + i), 1'b1);
      chk($sformatf("str%0d_vld", i), 32'(a_out_valid), 32'd1);
      chk($sformatf("str%0d_dat", i), a_out_data, 32'(i));
      chk($sformatf("str%0d_ctl", i), 32'(a_out_ctrl), 32'(8'h10 + i));
      chk($sformatf("str%0d_occ", i), 32'(a_occ), 32'd1);
    end
    a_in_valid = 1'b0;
    tick();
    a_empty("str_end");
    chk("str_hold", a_out_data, 32'h8);

    // skid fill
    a_push(32'hA, 8'h0A, 1'b1);
    chk("skA_dat", a_out_data, 32'hA);
    a_push(32'hB, 8'h0B, 1'b0);
    chk("skB_occ", 32'(a_occ), 32'd2);
    chk("skB_rdy", 32'(a_in_ready), 32'd0);
    chk("skB_dat", a_out_data, 32'hA);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("skout_dat", a_out_data, 32'hB);
    chk("skout_ctl", 32'(a_out_ctrl), 32'h0B);
    chk("skout_occ", 32'(a_occ), 32'd1);
    tick();
    a_empty("skout_end");

    // stall hold
    a_push(32'hDEAD, 8'h3C, 1'b1);
    a_push(32'hBEEF, 8'h3D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_push(32'h1000 + 32'(i), 8'h77, 1'b0);
      chk($sformatf("stl%0d_dat", i), a_out_data, 32'hDEAD);
      chk($sformatf("stl%0d_ctl", i), 32'(a_out_ctrl), 32'h3C);
      chk($sformatf("stl%0d_occ", i), 32'(a_occ), 32'd2);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("stl_next", a_out_data, 32'hBEEF);
    chk("stl_nctl", 32'(a_out_ctrl), 32'h3D);
    tick();
    a_empty("stl_end");

    // flush with occupancy 2 and same-cycle input
    a_push(32'h1, 8'h01, 1'b0);
    a_push(32'h2, 8'h02, 1'b0);
    chk("fl2_occ", 32'(a_occ), 32'd2);
    a_flush = 1'b1;
    a_push(32'hC, 8'h0C, 1'b1);
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    a_empty("fl2");
    tick();
    a_empty("fl2_after");

    // flush from ONE, where in_ready=1 and the input would be taken
    a_push(32'h3, 8'h03, 1'b0);
    chk("fl1_rdy", 32'(a_in_ready), 32'd1);
    a_flush = 1'b1;
    a_push(32'hC, 8'h0C, 1'b0);
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    a_empty("fl1");
    tick();
    a_empty("fl1_after");

    // async reset mid-stream with 2 entries held
    a_push(32'h5, 8'h05, 1'b0);
    a_push(32'h6, 8'h06, 1'b0);
    a_in_valid = 1'b0;
    chk("rs_occ2", 32'(a_occ), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    a_empty("rs_mid");
    chk("rs_rdy", 32'(a_in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_empty("rs_after");
    chk("rs_rdy2", 32'(a_in_ready), 32'd1);

    // SKID_EN=0 instance
    b_in_valid  = 1'b1;
    b_in_data   = 32'h11;
    b_in_ctrl   = 8'h21;
    b_out_ready = 1'b0;
    tick();
    chk("b_occ1", 32'(b_occ), 32'd1);
    chk("b_rdy0", 32'(b_in_ready), 32'd0);
    chk("b_dat1", b_out_data, 32'h11);
    tick();
    chk("b_hold", b_out_data, 32'h11);
    chk("b_occh", 32'(b_occ), 32'd1);
    b_in_data   = 32'h22;
    b_in_ctrl   = 8'h22;
    b_out_ready = 1'b1;
    #1;
    chk("b_rdy1", 32'(b_in_ready), 32'd1);
    tick();
    chk("b_dat2", b_out_data, 32'h22);
    chk("b_ctl2", 32'(b_out_ctrl), 32'h22);
    chk("b_occ2", 32'(b_occ), 32'd1);
    b_in_valid = 1'b0;
    tick();
    chk("b_vld0", 32'(b_out_valid), 32'd0);
    chk("b_bub", 32'(b_out_ctrl), 32'(BUB));
    chk("b_occ0", 32'(b_occ), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
